// File: rtl/run_sequencer_pkg.sv
// Shared types and defaults for the run sequencer.
// The TOUT state exists only when RUN_SEQ_WATCHDOG_EN is defined.
package run_seq_pkg;

  localparam int          CNT_W_DEF      = 16;
  localparam int unsigned WDOG_LIMIT_DEF = 32'h0000_FFF0;
  localparam int          RUNCNT_W       = 8;

`ifdef RUN_SEQ_WATCHDOG_EN
  typedef enum logic [2:0] {IDLE, ARMED, RUN, DONE, TOUT} run_state_t;
`else
  typedef enum logic [2:0] {IDLE, ARMED, RUN, DONE} run_state_t;
`endif

endpackage

// File: rtl/run_sequencer_if.sv
// Start/Ack handshake and performance counters between the top level and the sequencer.
interface run_sequencer_if #(
  parameter int CNT_W = 16
);

  logic                              Start;
  logic                              CoreAck;
  logic                              Run;
  logic                              PCReset;
  logic                              Ack;
  logic                              Timeout;
  logic [CNT_W-1:0]                  CycleCount;
  logic [run_seq_pkg::RUNCNT_W-1:0]  RunCount;

  modport master (
    output Start, CoreAck,
    input  Run, PCReset, Ack, Timeout, CycleCount, RunCount
  );

  modport slave (
    input  Start, CoreAck,
    output Run, PCReset, Ack, Timeout, CycleCount, RunCount
  );

endinterface

// File: rtl/run_sequencer_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge Clk) begin
    if (Reset || clr) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/run_sequencer.sv
// Run/halt controller: turns Start/CoreAck into Moore issue-enable, PC reset and Ack.
// Define RUN_SEQ_WATCHDOG_EN to abort runs that exceed WDOG_LIMIT cycles (TOUT state).
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int          CNT_W      = CNT_W_DEF,
  parameter int unsigned WDOG_LIMIT = WDOG_LIMIT_DEF
) (
  input  logic          Clk,
  input  logic          Reset,
  run_sequencer_if.slave bus
);

  run_state_t            r_state;
  run_state_t            w_next;
  logic [RUNCNT_W-1:0]   r_run_cnt;
  logic [CNT_W-1:0]      w_cycle;
  logic                  w_run_start;

`ifdef RUN_SEQ_WATCHDOG_EN
  localparam logic [CNT_W-1:0] WDOG_CMP = CNT_W'(WDOG_LIMIT);
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Start always wins over CoreAck (and the watchdog) so a run can be aborted.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (bus.Start) w_next = ARMED;
      ARMED: if (!bus.Start) w_next = RUN;
      RUN: begin
        if (bus.Start) begin
          w_next = ARMED;
        end else if (bus.CoreAck) begin
          w_next = DONE;
`ifdef RUN_SEQ_WATCHDOG_EN
        end else if (w_cycle == WDOG_CMP) begin
          w_next = TOUT;
`endif
        end
      end
      DONE:  if (bus.Start) w_next = ARMED;
`ifdef RUN_SEQ_WATCHDOG_EN
      TOUT:  if (bus.Start) w_next = ARMED;
`endif
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.Run     = 1'b0;
    bus.PCReset = 1'b0;
    bus.Ack     = 1'b0;
    bus.Timeout = 1'b0;
    unique case (r_state)
      ARMED: bus.PCReset = 1'b1;
      RUN:   bus.Run     = 1'b1;
      DONE:  bus.Ack     = 1'b1;
`ifdef RUN_SEQ_WATCHDOG_EN
      TOUT: begin
        bus.Ack     = 1'b1;
        bus.Timeout = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .Clk     (Clk),
    .Reset   (Reset),
    .clr     (r_state == ARMED),
    .inc     (r_state == RUN),
    .o_count (w_cycle)
  );

  assign w_run_start = (r_state == ARMED) && !bus.Start;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_run_cnt <= '0;
    end else if (w_run_start) begin
      r_run_cnt <= r_run_cnt + 1'b1;
    end
  end

  assign bus.CycleCount = w_cycle;
  assign bus.RunCount   = r_run_cnt;

endmodule

// File: tb/tb_run_sequencer.sv
// Randomized self-checking bench for run_sequencer against a transaction-level model.
module tb_run_sequencer;

  localparam int CNT_W = 8;
  localparam int LIMIT = 20;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   m_runs = 0;

  run_sequencer_if #(.CNT_W(CNT_W)) bus ();

  run_sequencer #(.CNT_W(CNT_W), .WDOG_LIMIT(LIMIT)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  // {Run, PCReset, Ack, Timeout}
  logic [3:0] ctl;
  assign ctl = {bus.Run, bus.PCReset, bus.Ack, bus.Timeout};

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_start(input int n);
    bus.Start = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.CoreAck = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (ctl !== 4'b0100) begin
        errors++;
        $display("FAIL armed_ctl cycle %0d: got %b want 0100", i, ctl);
      end
    end
    bus.Start   = 1'b0;
    bus.CoreAck = 1'($urandom_range(0, 1));
    tick();
    m_runs = (m_runs + 1) % 256;
    checks++;
    if ({ctl, bus.CycleCount, bus.RunCount} !== {4'b1000, CNT_W'(0), 8'(m_runs)}) begin
      errors++;
      $display("FAIL run_entry: ctl=%b cyc=%0d runs=%0d want ctl=1000 cyc=0 runs=%0d",
               ctl, bus.CycleCount, bus.RunCount, m_runs);
    end
    bus.CoreAck = 1'b0;
  endtask

  task automatic run_program(input int m, input bit halt);
    int exp_cnt;
    logic [3:0] want;
    for (int i = 1; i <= m; i++) begin
      bus.CoreAck = halt && (i == m);
      tick();
      exp_cnt = (i > SAT) ? SAT : i;
      want    = (halt && i == m) ? 4'b0010 : 4'b1000;
      checks++;
      if ({ctl, bus.CycleCount} !== {want, CNT_W'(exp_cnt)}) begin
        errors++;
        $display("FAIL run_cycle %0d: ctl=%b cyc=%0d want ctl=%b cyc=%0d",
                 i, ctl, bus.CycleCount, want, exp_cnt);
      end
    end
    bus.CoreAck = 1'b0;
  endtask

  task automatic hold(input int n, input logic [3:0] want, input int exp_cnt);
    for (int i = 0; i < n; i++) begin
      bus.CoreAck = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if ({ctl, bus.CycleCount, bus.RunCount} !== {want, CNT_W'(exp_cnt), 8'(m_runs)}) begin
        errors++;
        $display("FAIL hold %0d: ctl=%b cyc=%0d runs=%0d want ctl=%b cyc=%0d runs=%0d",
                 i, ctl, bus.CycleCount, bus.RunCount, want, exp_cnt, m_runs);
      end
    end
    bus.CoreAck = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    bus.Start = 1'b1;
    bus.CoreAck = 1'b1;
    tick();
    tick();
    checks++;
    if ({ctl, bus.CycleCount, bus.RunCount} !== '0) begin
      errors++;
      $display("FAIL reset_state: ctl=%b cyc=%0d runs=%0d want all 0",
               ctl, bus.CycleCount, bus.RunCount);
    end
    bus.Start = 1'b0;
    bus.CoreAck = 1'b0;
    Reset = 1'b0;
    m_runs = 0;
    tick();
    checks++;
    if (ctl !== 4'b0000) begin
      errors++;
      $display("FAIL idle_after_reset: ctl=%b want 0000", ctl);
    end
  endtask

  task automatic test_basic_run();
    do_start(3);
    run_program(10, 1'b1);
    hold(20, 4'b0010, 10);
  endtask

  task automatic test_restart();
    do_start(1);
    run_program(5, 1'b1);
    hold(3, 4'b0010, 5);
  endtask

  task automatic test_abort();
    do_start(2);
    run_program(3, 1'b0);
    bus.Start = 1'b1;
    bus.CoreAck = 1'b1;
    tick();
    checks++;
    if (ctl !== 4'b0100) begin
      errors++;
      $display("FAIL abort_priority: ctl=%b want 0100", ctl);
    end
    do_start(1);
    run_program(4, 1'b1);
  endtask

  task automatic test_random();
    int n;
    int m;
    for (int it = 0; it < 12; it++) begin
      n = $urandom_range(1, 4);
      m = $urandom_range(1, 18);
      do_start(n);
      if ($urandom_range(0, 3) == 0) begin
        run_program(m, 1'b0);
      end else begin
        run_program(m, 1'b1);
        hold($urandom_range(0, 5), 4'b0010, m);
      end
    end
  endtask

  task automatic test_limit();
    do_start(1);
`ifdef RUN_SEQ_WATCHDOG_EN
    run_program(LIMIT, 1'b0);
    tick();
    checks++;
    if ({ctl, bus.CycleCount} !== {4'b0011, CNT_W'(LIMIT + 1)}) begin
      errors++;
      $display("FAIL watchdog: ctl=%b cyc=%0d want ctl=0011 cyc=%0d",
               ctl, bus.CycleCount, LIMIT + 1);
    end
    hold(5, 4'b0011, LIMIT + 1);
`else
    run_program(SAT + 40, 1'b0);
    checks++;
    if ({bus.Timeout, bus.CycleCount} !== {1'b0, CNT_W'(SAT)}) begin
      errors++;
      $display("FAIL saturate: timeout=%b cyc=%0d want timeout=0 cyc=%0d",
               bus.Timeout, bus.CycleCount, SAT);
    end
`endif
    do_start(1);
    run_program(3, 1'b1);
  endtask

  task automatic test_reset_midrun();
    do_start(1);
    run_program(3, 1'b0);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    m_runs = 0;
    checks++;
    if ({ctl, bus.CycleCount, bus.RunCount} !== '0) begin
      errors++;
      $display("FAIL reset_midrun: ctl=%b cyc=%0d runs=%0d want all 0",
               ctl, bus.CycleCount, bus.RunCount);
    end
    bus.CoreAck = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({ctl, bus.CycleCount} !== '0) begin
        errors++;
        $display("FAIL idle_coreack %0d: ctl=%b cyc=%0d want all 0", i, ctl, bus.CycleCount);
      end
    end
    bus.CoreAck = 1'b0;
  endtask

  initial begin
    bus.Start   = 1'b0;
    bus.CoreAck = 1'b0;
    test_reset();
    test_basic_run();
    test_restart();
    test_abort();
    test_random();
    test_limit();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
